// File: rtl/edge_det_pkg.sv
// Shared types and default parameters for the edge detector bank.
// The edge qualification helper is used by every channel.
package edge_det_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_e;

    localparam int DEF_NCH         = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DEB_CYCLES  = 4;
    localparam int DEF_CNT_W       = 8;

    function automatic logic edge_qualifies(input edge_mode_e mode, input logic rising);
        logic result;
        result = 1'b0;
        case (mode)
            EDGE_RISE: result = rising;
            EDGE_FALL: result = !rising;
            EDGE_BOTH: result = 1'b1;
            default:   result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/edge_det_chan.sv
// One channel: synchroniser, debounce, edge qualification, sticky flag
// and saturating event counter.
module edge_det_chan
    import edge_det_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_ni,
    input  logic             sig,
    input  edge_mode_e       mode,
    input  logic             clr,
    output logic             level,
    output logic             pulse,
    output logic             pend,
    output logic [CNT_W-1:0] evt_cnt
);

    localparam int DEB_EFF = (DEB_CYCLES < 1) ? 1 : DEB_CYCLES;
    localparam int DW      = $clog2(DEB_EFF) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [DW-1:0]          deb_cnt;
    logic                   synced;
    logic                   differs;
    logic                   toggle;
    logic                   qualified;

    assign synced  = sync_q[SYNC_STAGES-1];
    assign differs = (synced != level);
    assign toggle  = differs && (deb_cnt == DW'(DEB_EFF - 1));
    // The level is about to flip, so a currently-low level means a rising edge.
    assign qualified = toggle && edge_qualifies(mode, !level);

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            deb_cnt <= '0;
            level   <= 1'b0;
            pulse   <= 1'b0;
            pend    <= 1'b0;
            evt_cnt <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig};

            if (!differs || toggle) begin
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end

            if (toggle) begin
                level <= ~level;
            end

            pulse <= qualified;

            // A new edge wins over a coincident clear for both flag and counter.
            if (qualified) begin
                pend <= 1'b1;
            end else if (clr) begin
                pend <= 1'b0;
            end

            if (clr) begin
                evt_cnt <= qualified ? CNT_W'(1) : '0;
            end else if (qualified && (evt_cnt != CNT_MAX)) begin
                evt_cnt <= evt_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/edge_det_bank.sv
// Bank of NCH independent debounced edge detectors sharing one clock and reset.
// Mode and counter fields are sliced per channel from the flat ports.
module edge_det_bank
    import edge_det_pkg::*;
#(
    parameter int NCH         = DEF_NCH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_ni,
    input  logic [NCH-1:0]       sig_i,
    input  logic [2*NCH-1:0]     mode_i,
    input  logic [NCH-1:0]       clr_i,
    output logic [NCH-1:0]       level_o,
    output logic [NCH-1:0]       pulse_o,
    output logic [NCH-1:0]       pend_o,
    output logic [NCH*CNT_W-1:0] evt_cnt_o
);

    for (genvar n = 0; n < NCH; n++) begin : g_chan
        edge_det_chan #(
            .SYNC_STAGES(SYNC_STAGES),
            .DEB_CYCLES (DEB_CYCLES),
            .CNT_W      (CNT_W)
        ) u_chan (
            .clk    (clk),
            .rst_ni (rst_ni),
            .sig    (sig_i[n]),
            .mode   (edge_mode_e'(mode_i[2*n +: 2])),
            .clr    (clr_i[n]),
            .level  (level_o[n]),
            .pulse  (pulse_o[n]),
            .pend   (pend_o[n]),
            .evt_cnt(evt_cnt_o[n*CNT_W +: CNT_W])
        );
    end

endmodule
